// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronizes the board reset, then releases a vector
// of active-low clears in a staggered order; also runs soft-reset sequences.
module rst_seq_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int NUM_OUT     = 3
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               soft_req,
   output logic               soft_ack,
   output logic [NUM_OUT-1:0] clrn_out,
   output logic               busy,
   output logic               all_released
);

   localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam int IW   = $clog2(NUM_OUT) + 1;

   typedef enum logic [2:0] {
      SYNC,
      HOLD,
      RELEASE,
      RUN,
      ACK
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_OUT-1:0]     out_q, out_d;
   logic                   soft_q, soft_d;
   logic                   done;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= SYNC;
         cnt_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         soft_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         soft_q  <= soft_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      out_d   = out_q;
      soft_d  = soft_q;
      done    = 1'b0;
      unique case (state_q)
         SYNC: begin
            if (synced) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               out_d[0] = 1'b1;
               cnt_d    = '0;
               if (NUM_OUT == 1) begin
                  done = 1'b1;
               end else begin
                  state_d = RELEASE;
                  idx_d   = IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            if (cnt_q == CW'(STAGE_GAP - 1)) begin
               out_d = out_q | (NUM_OUT'(1) << idx_q);
               cnt_d = '0;
               if (idx_q == IW'(NUM_OUT - 1)) begin
                  done = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (soft_req) begin
               out_d   = '0;
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               soft_d  = 1'b1;
            end
         end
         ACK: begin
            if (!soft_req) begin
               state_d = RUN;
               soft_d  = 1'b0;
            end
         end
         default: begin
            state_d = SYNC;
         end
      endcase
      // the last release edge also decides where the handshake goes
      if (done) begin
         state_d = soft_q ? ACK : RUN;
      end
   end

   assign clrn_out     = out_q;
   assign soft_ack     = (state_q == ACK);
   assign all_released = (state_q == RUN) || (state_q == ACK);
   assign busy         = !all_released;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: scoreboarded per-edge expectations for
// power-on, soft reset, async/glitch reset, early request and a 1-output build.
module tb_rst_seq_gen;

   localparam int S = 2;
   localparam int H = 16;
   localparam int G = 4;
   localparam int N = 3;

   typedef struct packed {
      logic [2:0] co;
      logic       busy;
      logic       ar;
      logic       ack;
   } exp_t;

   logic         clk = 1'b0;
   logic         clrn;
   logic         soft_req;
   logic         soft_ack;
   logic [N-1:0] clrn_out;
   logic         busy;
   logic         all_released;

   logic         clrn2;
   logic         soft_req2;
   logic         soft_ack2;
   logic [0:0]   clrn_out2;
   logic         busy2;
   logic         all_released2;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rst_seq_gen #(
      .SYNC_STAGES(S),
      .HOLD_CYCLES(H),
      .STAGE_GAP  (G),
      .NUM_OUT    (N)
   ) dut (
      .clk         (clk),
      .clrn        (clrn),
      .soft_req    (soft_req),
      .soft_ack    (soft_ack),
      .clrn_out    (clrn_out),
      .busy        (busy),
      .all_released(all_released)
   );

   rst_seq_gen #(
      .SYNC_STAGES(2),
      .HOLD_CYCLES(1),
      .STAGE_GAP  (4),
      .NUM_OUT    (1)
   ) dut1 (
      .clk         (clk),
      .clrn        (clrn2),
      .soft_req    (soft_req2),
      .soft_ack    (soft_ack2),
      .clrn_out    (clrn_out2),
      .busy        (busy2),
      .all_released(all_released2)
   );

   function automatic exp_t mk(input logic [2:0] co, input logic ack);
      exp_t e;
      e.co   = co;
      e.busy = ~&co;
      e.ar   = &co;
      e.ack  = ack;
      return e;
   endfunction

   // state after power-on edge Ek
   function automatic exp_t po_exp(input int k);
      logic [2:0] co;
      for (int i = 0; i < N; i++) co[i] = (k >= S + H + i * G);
      return mk(co, 1'b0);
   endfunction

   // state after soft-reset edge Fk (request held high)
   function automatic exp_t sr_exp(input int k);
      logic [2:0] co;
      for (int i = 0; i < N; i++) co[i] = (k >= H + i * G);
      return mk(co, k >= H + (N - 1) * G);
   endfunction

   function automatic exp_t obs(input bit which);
      exp_t o;
      if (which) begin
         o.co   = {2'b11, clrn_out2};
         o.busy = busy2;
         o.ar   = all_released2;
         o.ack  = soft_ack2;
      end else begin
         o.co   = clrn_out;
         o.busy = busy;
         o.ar   = all_released;
         o.ack  = soft_ack;
      end
      return o;
   endfunction

   task automatic chk(input string tag, input bit which, input exp_t e);
      exp_t o;
      o = obs(which);
      checks++;
      assert (o === e)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic drain(input string tag, input bit which);
      exp_t e;
      int   n;
      n = 0;
      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         e = q.pop_front();
         chk($sformatf("%s[%0d]", tag, n), which, e);
         n++;
      end
   endtask

   initial begin
      clrn      = 1'b0;
      soft_req  = 1'b0;
      clrn2     = 1'b0;
      soft_req2 = 1'b0;
      #1;
      chk("reset", 1'b0, mk(3'b000, 1'b0));
      chk("reset1", 1'b1, mk(3'b110, 1'b0));

      // power-on
      repeat (3) @(posedge clk);
      @(negedge clk);
      clrn = 1'b1;
      for (int k = 0; k <= 27; k++) q.push_back(po_exp(k));
      drain("poweron", 1'b0);

      // soft reset
      @(negedge clk);
      soft_req = 1'b1;
      for (int k = 0; k <= 25; k++) q.push_back(sr_exp(k));
      drain("soft", 1'b0);
      @(negedge clk);
      soft_req = 1'b0;
      q.push_back(mk(3'b111, 1'b0));
      q.push_back(mk(3'b111, 1'b0));
      drain("ackdrop", 1'b0);

      // async reset mid-release
      clrn = 1'b0;
      #1;
      chk("async0", 1'b0, mk(3'b000, 1'b0));
      @(negedge clk);
      clrn = 1'b1;
      for (int k = 0; k <= 23; k++) q.push_back(po_exp(k));
      drain("pre_abort", 1'b0);
      #2;
      clrn = 1'b0;
      #1;
      chk("abort", 1'b0, mk(3'b000, 1'b0));
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
      for (int k = 0; k <= 26; k++) q.push_back(po_exp(k));
      drain("restart", 1'b0);

      // early request held through power-on
      clrn     = 1'b0;
      soft_req = 1'b1;
      #1;
      chk("early_rst", 1'b0, mk(3'b000, 1'b0));
      @(negedge clk);
      clrn = 1'b1;
      for (int k = 0; k <= 26; k++) q.push_back(po_exp(k));
      for (int k = 0; k <= 24; k++) q.push_back(sr_exp(k));
      drain("early", 1'b0);
      @(negedge clk);
      soft_req = 1'b0;
      q.push_back(mk(3'b111, 1'b0));
      drain("early_ack", 1'b0);

      // short glitch while running
      @(negedge clk);
      #1;
      clrn = 1'b0;
      #2;
      clrn = 1'b1;
      #1;
      chk("glitch", 1'b0, mk(3'b000, 1'b0));
      for (int k = 0; k <= 26; k++) q.push_back(po_exp(k));
      drain("glitch_seq", 1'b0);

      // single-output build
      @(negedge clk);
      clrn2 = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         q.push_back(mk({2'b11, 1'(k >= 3)}, 1'b0));
      end
      drain("one", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
